// File: rtl/pbx_bus_pkg.sv
// Shared definitions for the PBX CPLD command bus: command codes and
// the frame sequencer state type.
package pbx_bus_pkg;

    localparam logic [3:0] CMD_TRST      = 4'd0;
    localparam logic [3:0] CMD_TONECK    = 4'd1;
    localparam logic [3:0] CMD_COMECK    = 4'd2;
    localparam logic [3:0] CMD_CS0_LO    = 4'd5;
    localparam logic [3:0] CMD_CS1_LO    = 4'd6;
    localparam logic [3:0] CMD_RLY_EXT   = 4'd7;
    localparam logic [3:0] CMD_RLY_TRK   = 4'd8;
    localparam logic [3:0] CMD_PLAY_ON   = 4'd9;
    localparam logic [3:0] CMD_PLAY_OFF  = 4'd10;
    localparam logic [3:0] CMD_REC_ON    = 4'd11;
    localparam logic [3:0] CMD_REC_OFF   = 4'd12;
    localparam logic [3:0] CMD_CS0_HI    = 4'd13;
    localparam logic [3:0] CMD_CS1_HI    = 4'd14;
    localparam logic [3:0] CMD_RESET_ALL = 4'd15;

    // Fall ticks spent in SETUP after the one that loads p2, before cs_n drops.
    // Two ALE rises with the new code and cs_n high: latch, then decode.
    localparam int unsigned SETUP_HOLD_FALLS = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_RECOVER
    } pbx_state_t;

endpackage

// File: rtl/pbx_ale_gen.sv
// Free-running ALE generator: ale toggles every ALE_DIV clk cycles; the
// wrap cycle is flagged as a rise tick (ale about to go high) or a fall
// tick (ale about to go low).
module pbx_ale_gen #(
    parameter int unsigned ALE_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic ale,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned CW = (ALE_DIV > 1) ? $clog2(ALE_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap      = (cnt == CW'(ALE_DIV - 1));
    assign rise_tick = wrap && !ale;
    assign fall_tick = wrap && ale;

    // Divider count and ale toggle at each wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            ale <= 1'b0;
        end else if (wrap) begin
            cnt <= '0;
            ale <= ~ale;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pbx_cmd_issuer.sv
// Host-side PBX command initiator: accepts a 4-bit code over valid/ready and
// emits one complete p2/cs_n frame aligned to the free-running ALE strobe.
module pbx_cmd_issuer
    import pbx_bus_pkg::*;
#(
    parameter int unsigned ALE_DIV       = 4,
    parameter int unsigned LOW_EDGES     = 1,
    parameter int unsigned RECOVER_EDGES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_code,
    output logic       cmd_ready,
    output logic       cmd_done,
    output logic       busy,
    output logic [3:0] p2,
    output logic       ale,
    output logic       cs_n
);

    localparam int unsigned RW = $clog2(RECOVER_EDGES + 1);

    logic          rise_tick;
    logic          fall_tick;

    pbx_state_t    state, state_n;
    logic [3:0]    code_q, code_n;
    logic [3:0]    p2_q, p2_n;
    logic          cs_n_q, cs_n_d;
    logic [1:0]    setup_cnt, setup_cnt_n;
    logic [1:0]    low_cnt, low_cnt_n;
    logic [RW-1:0] rec_cnt, rec_cnt_n;
    logic          done_c;

    pbx_ale_gen #(
        .ALE_DIV(ALE_DIV)
    ) u_ale_gen (
        .clk       (clk),
        .rst       (rst),
        .ale       (ale),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // State, captured code, bus pins and edge counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            code_q    <= '0;
            p2_q      <= '0;
            cs_n_q    <= 1'b1;
            setup_cnt <= '0;
            low_cnt   <= '0;
            rec_cnt   <= '0;
        end else begin
            state     <= state_n;
            code_q    <= code_n;
            p2_q      <= p2_n;
            cs_n_q    <= cs_n_d;
            setup_cnt <= setup_cnt_n;
            low_cnt   <= low_cnt_n;
            rec_cnt   <= rec_cnt_n;
        end
    end

    // Frame sequencing: every p2/cs_n change lands on a fall tick.
    always_comb begin
        state_n     = state;
        code_n      = code_q;
        p2_n        = p2_q;
        cs_n_d      = cs_n_q;
        setup_cnt_n = setup_cnt;
        low_cnt_n   = low_cnt;
        rec_cnt_n   = rec_cnt;
        done_c      = 1'b0;

        case (state)
            ST_IDLE: begin
                cs_n_d = 1'b1;
                if (cmd_valid) begin
                    code_n      = cmd_code;
                    setup_cnt_n = '0;
                    state_n     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                // First fall tick loads p2; the code then sits through two
                // ALE rises with cs_n high before cs_n is pulled low.
                if (fall_tick) begin
                    if (setup_cnt == 2'(SETUP_HOLD_FALLS)) begin
                        cs_n_d    = 1'b0;
                        low_cnt_n = '0;
                        state_n   = ST_ACTIVE;
                    end else begin
                        if (setup_cnt == '0) begin
                            p2_n = code_q;
                        end
                        setup_cnt_n = setup_cnt + 2'd1;
                    end
                end
            end

            ST_ACTIVE: begin
                if (fall_tick && (low_cnt == 2'(LOW_EDGES))) begin
                    cs_n_d    = 1'b1;
                    rec_cnt_n = '0;
                    state_n   = ST_RECOVER;
                end else if (rise_tick) begin
                    low_cnt_n = low_cnt + 2'd1;
                end
            end

            ST_RECOVER: begin
                if (fall_tick && (rec_cnt == RW'(RECOVER_EDGES))) begin
                    done_c  = 1'b1;
                    state_n = ST_IDLE;
                end else if (rise_tick) begin
                    rec_cnt_n = rec_cnt + 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign cmd_done  = done_c;
    assign p2        = p2_q;
    assign cs_n      = cs_n_q;

endmodule

// File: tb/tb_pbx_cmd_issuer.sv
`timescale 1ns/1ps
module tb_pbx_cmd_issuer;

    logic       clk;
    logic       rst_a, rst_b;
    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       sel;

    logic       ready_a, done_a, busy_a, ale_a, cs_a;
    logic [3:0] p2_a;
    logic       ready_b, done_b, busy_b, ale_b, cs_b;
    logic [3:0] p2_b;

    logic       o_ready, o_done, o_busy, o_ale, o_cs_n, o_rst;
    logic [3:0] o_p2;

    int vectors;
    int miscompares;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    pbx_cmd_issuer u_dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (ready_a),
        .cmd_done  (done_a),
        .busy      (busy_a),
        .p2        (p2_a),
        .ale       (ale_a),
        .cs_n      (cs_a)
    );

    pbx_cmd_issuer #(
        .ALE_DIV       (1),
        .LOW_EDGES     (3),
        .RECOVER_EDGES (5)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (ready_b),
        .cmd_done  (done_b),
        .busy      (busy_b),
        .p2        (p2_b),
        .ale       (ale_b),
        .cs_n      (cs_b)
    );

    assign o_ready = sel ? ready_b : ready_a;
    assign o_done  = sel ? done_b  : done_a;
    assign o_busy  = sel ? busy_b  : busy_a;
    assign o_ale   = sel ? ale_b   : ale_a;
    assign o_cs_n  = sel ? cs_b    : cs_a;
    assign o_p2    = sel ? p2_b    : p2_a;
    assign o_rst   = sel ? rst_b   : rst_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int min);
        vectors++;
        if (act < min) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected at least %0d (t=%0t)", name, act, min, $time);
        end
    endtask

    // Reference model: the frame is derived from the handshake cycle with
    // plain arithmetic on the ALE period.
    int unsigned m_t, m_f0;
    bit          m_busy, m_valid;
    logic [3:0]  m_code, m_p2_prev;
    logic        last_sel;

    initial begin : model_cmp
        int unsigned d, l, r, p, done_t;
        logic       e_ale, e_cs, e_done, e_ready;
        logic [3:0] e_p2;
        m_valid  = 1'b0;
        m_busy   = 1'b0;
        m_t      = 0;
        m_f0     = 0;
        last_sel = 1'b0;
        forever begin
            @(negedge clk);
            d = sel ? 1 : 4;
            l = sel ? 3 : 1;
            r = sel ? 5 : 3;
            p = 2 * d;
            done_t = m_f0 + (2 + l + r) * p;
            if (sel != last_sel) begin
                m_valid  = 1'b0;
                last_sel = sel;
            end
            if (m_valid) begin
                e_ale   = ((m_t / d) % 2) == 1;
                e_ready = !m_busy;
                e_done  = m_busy && (m_t == done_t);
                e_cs    = !(m_busy && (m_t > m_f0 + 2 * p) && (m_t <= m_f0 + (2 + l) * p));
                e_p2    = (m_busy && (m_t > m_f0)) ? m_code : m_p2_prev;
                chk("m_ale",   o_ale,   e_ale);
                chk("m_ready", o_ready, e_ready);
                chk("m_busy",  o_busy,  !e_ready);
                chk("m_done",  o_done,  e_done);
                chk("m_cs_n",  o_cs_n,  e_cs);
                chk("m_p2",    o_p2,    e_p2);
            end
            if (o_rst) begin
                m_t       = 0;
                m_busy    = 1'b0;
                m_p2_prev = 4'h0;
                m_valid   = 1'b1;
            end else if (m_valid) begin
                if (m_busy && (m_t == done_t)) begin
                    m_busy    = 1'b0;
                    m_p2_prev = m_code;
                end else if (!m_busy && cmd_valid) begin
                    m_busy = 1'b1;
                    m_code = cmd_code;
                    m_f0   = m_t + (p - 1) - (m_t % p);
                    if (m_f0 == m_t) m_f0 = m_f0 + p;
                end
                m_t++;
            end
        end
    end

    // Observed bus statistics, sampled 1 ns after each rising clk edge.
    int   cnum = 0;
    int   hs_cnum = -1, f0_cnum = -1, done_cnum = -1;
    int   low_rises = 0, high_run = 0, last_high_run = 0;
    int   p2_run = 0, p2_stable = 0;
    logic [3:0] p2_run_val = 4'h0, p2_pre = 4'h0;
    bit   first_low = 1'b0, done_seen = 1'b0, last_rose = 1'b0;
    logic ale_prev = 1'b0;

    task automatic tick();
        if (cmd_valid && o_ready && !o_rst) begin
            hs_cnum   = cnum;
            f0_cnum   = -1;
            low_rises = 0;
            first_low = 1'b0;
        end
        if (o_done) begin
            done_seen = 1'b1;
            done_cnum = cnum;
        end
        @(posedge clk);
        #1;
        cnum++;
        last_rose = !ale_prev && o_ale;
        if (ale_prev && !o_ale && (f0_cnum < 0) && (cnum - 1 > hs_cnum))
            f0_cnum = cnum - 1;
        ale_prev = o_ale;
        if (last_rose) begin
            if (!o_cs_n) begin
                low_rises++;
                if (!first_low) begin
                    first_low     = 1'b1;
                    last_high_run = high_run;
                    p2_pre        = p2_run_val;
                    p2_stable     = p2_run;
                end
                high_run = 0;
            end else begin
                high_run++;
                if (o_p2 == p2_run_val) p2_run++;
                else begin
                    p2_run_val = o_p2;
                    p2_run     = 1;
                end
            end
        end
    endtask

    task automatic wait_done(input int bound);
        done_seen = 1'b0;
        for (int i = 0; i < bound && !done_seen; i++) tick();
        chk("done_within_bound", done_seen, 1);
    endtask

    initial begin : stim
        int first_rise, second_rise, low_cycles, prev_done;
        vectors     = 0;
        miscompares = 0;
        sel         = 1'b0;
        rst_a       = 1'b1;
        rst_b       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_code    = 4'h0;
        tick();
        tick();
        rst_a = 1'b0;

        // Reset state and idle ALE behaviour.
        chk("rst_cs_n",  o_cs_n,  1);
        chk("rst_p2",    o_p2,    0);
        chk("rst_ready", o_ready, 1);
        chk("rst_busy",  o_busy,  0);
        chk("rst_ale",   o_ale,   0);
        chk("rst_done",  o_done,  0);
        first_rise  = -1;
        second_rise = -1;
        low_cycles  = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!o_cs_n) low_cycles++;
            if (last_rose) begin
                if (first_rise < 0) first_rise = cnum;
                else if (second_rise < 0) second_rise = cnum;
            end
        end
        chk("ale_period", second_rise - first_rise, 8);
        chk("idle_cs_low_cycles", low_cycles, 0);

        // Single frame, code 9.
        cmd_code  = 4'd9;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_done(200);
        chk("f9_len", done_cnum - f0_cnum, 48);
        chk("f9_low_rises", low_rises, 1);
        chk("f9_p2_at_high_rise", p2_pre, 9);
        chk_ge("f9_p2_stable_rises", p2_stable, 2);

        // Back-to-back 7 then 8 with cmd_valid held.
        repeat (3) tick();
        cmd_code  = 4'd7;
        cmd_valid = 1'b1;
        tick();
        cmd_code = 4'd8;
        wait_done(200);
        chk("b2b_first_p2", p2_pre, 7);
        prev_done = done_cnum;
        tick();
        chk("b2b_handshake_gap", hs_cnum - prev_done, 1);
        cmd_valid = 1'b0;
        wait_done(200);
        chk_ge("b2b_high_rises", last_high_run, 4);
        chk("b2b_second_p2", p2_pre, 8);
        chk("b2b_second_len", done_cnum - f0_cnum, 48);

        // cmd_code changes one cycle after the handshake.
        repeat (5) tick();
        cmd_code  = 4'd9;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_code  = 4'd10;
        wait_done(200);
        chk("late_code_p2_pre", p2_pre, 9);
        chk("late_code_p2_now", o_p2, 9);

        // Reset while ACTIVE.
        repeat (2) tick();
        cmd_code  = 4'd3;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 100 && o_cs_n; i++) tick();
        chk("mid_rst_reached_active", o_cs_n, 0);
        tick();
        rst_a = 1'b1;
        tick();
        chk("mid_rst_cs_n",  o_cs_n,  1);
        chk("mid_rst_ale",   o_ale,   0);
        chk("mid_rst_ready", o_ready, 1);
        chk("mid_rst_p2",    o_p2,    0);
        rst_a = 1'b0;

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_code  = 4'($urandom_range(0, 15));
            rst_a     = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst_a     = 1'b0;
        cmd_valid = 1'b0;
        tick();

        // Second configuration: ALE_DIV=1, LOW_EDGES=3, RECOVER_EDGES=5.
        sel   = 1'b1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        rst_b = 1'b0;
        chk("b_rst_cs_n",  o_cs_n,  1);
        chk("b_rst_ready", o_ready, 1);
        repeat (3) tick();
        cmd_code  = 4'd15;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_done(100);
        chk("b_f15_len", done_cnum - f0_cnum, 20);
        chk("b_f15_low_rises", low_rises, 3);
        chk("b_f15_p2", p2_pre, 15);

        for (int i = 0; i < 300; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_code  = 4'($urandom_range(0, 15));
            rst_b     = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst_b     = 1'b0;
        cmd_valid = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
